// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg -- shared state encoding, requester count and defaults for the UART scheduler.
// Rev 1.0
package uart_pkg;

  localparam int unsigned N_REQ           = 4;
  localparam logic [3:0]  DEF_HDR_PREFIX  = 4'hA;
  localparam logic [15:0] DEF_TIMEOUT_CYC = 16'd60000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR      = 3'd1,
    WAIT_HDR = 3'd2,
    PAY      = 3'd3,
    WAIT_PAY = 3'd4
  } state_t;

  function automatic logic [7:0] hdr_byte(input logic [3:0] prefix, input logic [1:0] id);
    return {prefix, 2'b00, id};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// rr_arbiter4 -- combinational 4-way round-robin pick starting at ptr.
// Rev 1.0
module rr_arbiter4
  import uart_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       gnt_id,
  output logic             any
);

  always_comb begin
    gnt_id = ptr;
    any    = |req;
    // Walk from the farthest offset down so the nearest requester to ptr wins.
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        gnt_id = ptr + 2'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// uart_tx_sched -- round-robin scheduler sending a header byte then a payload byte per grant.
// Rev 1.0
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter logic [3:0]  HDR_PREFIX  = DEF_HDR_PREFIX,
  parameter logic [15:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        tx_ready,
  output logic [1:0]  grant_id,
  output logic        sched_busy,
  output logic        timeout_err
);

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic [7:0]  pay_reg_q, pay_reg_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [15:0] wd_q, wd_d;
  logic [1:0]  arb_id;
  logic        arb_any;
  logic        wd_expired;

  rr_arbiter4 u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  assign wd_expired = (wd_q == TIMEOUT_CYC - 16'd1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    pay_reg_d   = pay_reg_q;
    tx_data_d   = tx_data_q;
    wd_d        = wd_q;
    req_ready   = '0;
    tx_start    = 1'b0;
    timeout_err = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready[arb_id] = 1'b1;
          grant_id_d        = arb_id;
          pay_reg_d         = req_data[{arb_id, 3'b000} +: 8];
          rr_ptr_d          = arb_id + 2'd1;
          state_d           = HDR;
        end
      end
      HDR: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          tx_data_d = hdr_byte(HDR_PREFIX, grant_id_q);
          state_d   = WAIT_HDR;
        end
      end
      PAY: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          tx_data_d = pay_reg_q;
          state_d   = WAIT_PAY;
        end
      end
      WAIT_HDR, WAIT_PAY: begin
        // A completion arriving on the expiry cycle still counts as success.
        if (tx_ready) begin
          state_d = (state_q == WAIT_HDR) ? PAY : IDLE;
        end else if (wd_expired) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tx_start) begin
      wd_d = '0;
    end

    // Outputs that act on the outside world are silenced while reset is held.
    if (reset) begin
      req_ready   = '0;
      tx_start    = 1'b0;
      timeout_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      pay_reg_q  <= '0;
      tx_data_q  <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      pay_reg_q  <= pay_reg_d;
      tx_data_q  <= tx_data_d;
      wd_q       <= wd_d;
    end
  end

  assign tx_data    = tx_start ? tx_data_d : tx_data_q;
  assign grant_id   = grant_id_q;
  assign sched_busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// tb_uart_tx_sched -- directed scenarios and random traffic checked against a packet-level model.
// Rev 1.0
module tb_uart_tx_sched;

  localparam logic [15:0] TO  = 16'd16;
  localparam logic [3:0]  PFX = 4'hA;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        sched_busy;
  logic        timeout_err;

  uart_tx_sched #(.HDR_PREFIX(PFX), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .sched_busy  (sched_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Environment: requesters and a transmitter that answers after a latency.
  logic       rst_req;
  logic [3:0] rq_valid;
  logic [7:0] rq_data [4];
  int         req_mode;   // 0 drop on grant, 1 new byte on grant, 2 keep byte, 3 random
  int         lat_cfg;    // >0 fixed latency, 0 never answers, -1 random
  bit         rnd_env;
  int         busy_hold;
  bit         stray_once;
  int         tx_cnt;
  bit         tx_will;

  // Model: packet in flight is a queue of bytes still to launch.
  bit         m_known, m_active, m_wait;
  int         m_rr, m_deadline;
  logic [1:0] m_gid;
  logic [7:0] m_last;
  logic [7:0] m_bytes[$];

  typedef struct { int c; int v; } ev_t;
  ev_t byte_log[$];
  ev_t gnt_log[$];
  int  to_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    byte_log.delete();
    gnt_log.delete();
    to_log.delete();
  endtask

  task automatic drive();
    reset = rst_req || (rnd_env && $urandom_range(0, 399) == 0);
    if (rnd_env) begin
      for (int i = 0; i < 4; i++) begin
        if (!rq_valid[i] && $urandom_range(0, 3) == 0) begin
          rq_valid[i] = 1'b1;
          rq_data[i]  = 8'($urandom);
        end else if (rq_valid[i] && $urandom_range(0, 31) == 0) begin
          rq_valid[i] = 1'b0;
        end
      end
    end
    if (tx_cnt > 0) begin
      tx_cnt--;
      tx_busy  = (tx_cnt != 0);
      tx_ready = (tx_cnt == 0) && tx_will;
    end else begin
      tx_busy    = (busy_hold > 0) || (rnd_env && $urandom_range(0, 3) == 0);
      tx_ready   = stray_once || (rnd_env && $urandom_range(0, 15) == 0);
      stray_once = 1'b0;
    end
    if (busy_hold > 0) busy_hold--;
    req_valid = rq_valid;
    for (int i = 0; i < 4; i++) req_data[8*i +: 8] = rq_data[i];
  endtask

  task automatic model_step();
    logic [3:0] e_ready;
    logic       e_start, e_to, e_busy;
    logic [7:0] e_data;
    logic [1:0] e_gid;
    int         g;
    e_ready = '0; e_start = 1'b0; e_to = 1'b0;
    e_data  = m_last; e_gid = m_gid; e_busy = m_active;
    g = 0;
    if (!reset) begin
      if (!m_active) begin
        if (req_valid != 4'b0) begin
          for (int k = 3; k >= 0; k--) if (req_valid[(m_rr + k) % 4]) g = (m_rr + k) % 4;
          e_ready[g] = 1'b1;
        end
      end else if (!m_wait) begin
        if (!tx_busy) begin
          e_start = 1'b1;
          e_data  = m_bytes[0];
        end
      end else if (!tx_ready && cyc == m_deadline) begin
        e_to = 1'b1;
      end
    end

    if (m_known) begin
      chk("req_ready",   32'(req_ready),   32'(e_ready));
      chk("tx_start",    32'(tx_start),    32'(e_start));
      chk("tx_data",     32'(tx_data),     32'(e_data));
      chk("grant_id",    32'(grant_id),    32'(e_gid));
      chk("sched_busy",  32'(sched_busy),  32'(e_busy));
      chk("timeout_err", 32'(timeout_err), 32'(e_to));
    end

    if (reset) begin
      m_known = 1'b1; m_active = 1'b0; m_wait = 1'b0;
      m_rr = 0; m_gid = '0; m_last = '0;
      m_bytes.delete();
    end else if (!m_active) begin
      if (e_ready != 4'b0) begin
        m_gid = 2'(g);
        m_bytes.delete();
        m_bytes.push_back({PFX, 2'b00, 2'(g)});
        m_bytes.push_back(req_data[8*g +: 8]);
        m_rr = (g + 1) % 4;
        m_active = 1'b1;
        m_wait = 1'b0;
        gnt_log.push_back('{cyc, g});
        case (req_mode)
          1:       rq_data[g] = 8'($urandom);
          2:       ;
          default: rq_valid[g] = 1'b0;
        endcase
      end
    end else if (!m_wait) begin
      if (e_start) begin
        m_last = e_data;
        void'(m_bytes.pop_front());
        m_wait = 1'b1;
        m_deadline = cyc + int'(TO);
        byte_log.push_back('{cyc, int'(e_data)});
        if (lat_cfg > 0) begin
          tx_cnt = lat_cfg; tx_will = 1'b1;
        end else if (lat_cfg == 0 || $urandom_range(0, 9) == 0) begin
          tx_cnt = 20; tx_will = 1'b0;
        end else begin
          tx_cnt = $urandom_range(1, 20); tx_will = 1'b1;
        end
      end
    end else if (tx_ready) begin
      m_wait = 1'b0;
      if (m_bytes.size() == 0) m_active = 1'b0;
    end else if (e_to) begin
      m_active = 1'b0; m_wait = 1'b0;
      m_bytes.delete();
      to_log.push_back(cyc);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1 drive();
      #3 model_step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_req = 1'b1; rq_valid = '0; req_mode = 0; lat_cfg = 3; rnd_env = 1'b0;
    busy_hold = 0; stray_once = 1'b0; tx_cnt = 0; tx_will = 1'b0;
    for (int i = 0; i < 4; i++) rq_data[i] = '0;
    m_known = 1'b0; m_active = 1'b0; m_wait = 1'b0; m_rr = 0; m_deadline = 0;
    m_gid = '0; m_last = '0;
    reset = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0; tx_ready = 1'b0;

    // Reset values.
    step(2);
    rst_req = 1'b0;
    step(1);
    chk("rst_req_ready",  32'(req_ready),   32'h0);
    chk("rst_tx_start",   32'(tx_start),    32'h0);
    chk("rst_tx_data",    32'(tx_data),     32'h0);
    chk("rst_grant_id",   32'(grant_id),    32'h0);
    chk("rst_sched_busy", 32'(sched_busy),  32'h0);
    chk("rst_timeout",    32'(timeout_err), 32'h0);

    // Single request from requester 1.
    clear_logs();
    rq_data[1] = 8'h5C; rq_valid = 4'b0010;
    step(40);
    chk("single_ngrant", gnt_log.size(), 1);
    chk("single_nbytes", byte_log.size(), 2);
    if (gnt_log.size() >= 1 && byte_log.size() >= 2) begin
      chk("single_gid",     gnt_log[0].v, 1);
      chk("single_hdr",     byte_log[0].v, 32'hA1);
      chk("single_pay",     byte_log[1].v, 32'h5C);
      chk("single_hdr_lat", byte_log[0].c - gnt_log[0].c, 1);
      chk("single_pay_lat", byte_log[1].c - byte_log[0].c, 4);
    end

    // All four requesters valid from reset.
    rst_req = 1'b1; req_mode = 1; rq_valid = 4'b1111;
    for (int i = 0; i < 4; i++) rq_data[i] = 8'($urandom);
    step(2);
    clear_logs();
    rst_req = 1'b0;
    step(60);
    chk("rr_ngrant", 32'(gnt_log.size() >= 5), 1);
    if (gnt_log.size() >= 5 && byte_log.size() >= 9) begin
      for (int k = 0; k < 5; k++) begin
        chk("rr_gid", gnt_log[k].v, k % 4);
        chk("rr_hdr", byte_log[2*k].v, 32'hA0 + (k % 4));
      end
    end

    // Transmitter never answers: watchdog expiry.
    rst_req = 1'b1; req_mode = 0; lat_cfg = 0; rq_valid = 4'b0011;
    step(2);
    clear_logs();
    rst_req = 1'b0;
    step(70);
    chk("to_count", 32'(to_log.size() >= 1), 1);
    if (to_log.size() >= 1 && byte_log.size() >= 1 && gnt_log.size() >= 2) begin
      chk("to_delay",      to_log[0] - byte_log[0].c, 16);
      chk("to_next_gid",   gnt_log[1].v, 1);
      chk("to_next_cycle", gnt_log[1].c - to_log[0], 1);
    end

    // Reset while the payload is in flight.
    rst_req = 1'b1; req_mode = 2; lat_cfg = 3; rq_valid = 4'b0100; rq_data[2] = 8'h3C;
    step(2);
    clear_logs();
    rst_req = 1'b0;
    for (int i = 0; i < 40 && byte_log.size() < 2; i++) step(1);
    chk("wp_reached", byte_log.size(), 2);
    rst_req = 1'b1;
    step(1);
    rst_req = 1'b0;
    clear_logs();
    step(1);
    chk("wp_req_ready",  32'(req_ready),   32'h4);
    chk("wp_tx_start",   32'(tx_start),    32'h0);
    chk("wp_tx_data",    32'(tx_data),     32'h0);
    chk("wp_grant_id",   32'(grant_id),    32'h0);
    chk("wp_sched_busy", 32'(sched_busy),  32'h0);
    chk("wp_timeout",    32'(timeout_err), 32'h0);
    step(10);
    if (gnt_log.size() >= 1 && byte_log.size() >= 1) begin
      chk("wp_regid", gnt_log[0].v, 2);
      chk("wp_rehdr", byte_log[0].v, 32'hA2);
    end else begin
      chk("wp_reserved", 32'(gnt_log.size() + byte_log.size() >= 2), 1);
    end
    req_mode = 0; rq_valid = '0;

    // Transmitter busy for five cycles while the header waits.
    rst_req = 1'b1;
    step(2);
    rst_req = 1'b0;
    step(25);
    clear_logs();
    rq_valid = 4'b1000; rq_data[3] = 8'h77; busy_hold = 6;
    step(30);
    chk("busy_nbytes", byte_log.size(), 2);
    if (gnt_log.size() >= 1 && byte_log.size() >= 2) begin
      chk("busy_delay", byte_log[0].c - gnt_log[0].c, 6);
      chk("busy_hdr",   byte_log[0].v, 32'hA3);
      chk("busy_pay",   byte_log[1].v, 32'h77);
    end

    // Stray completion pulse while idle.
    stray_once = 1'b1;
    step(1);
    chk("stray_ready", 32'(req_ready),  32'h0);
    chk("stray_busy",  32'(sched_busy), 32'h0);
    step(1);
    chk("stray_busy2", 32'(sched_busy), 32'h0);
    clear_logs();
    rq_valid = 4'b0001; rq_data[0] = 8'h11;
    step(20);
    if (byte_log.size() >= 2) begin
      chk("stray_hdr", byte_log[0].v, 32'hA0);
      chk("stray_pay", byte_log[1].v, 32'h11);
    end else begin
      chk("stray_nbytes", byte_log.size(), 2);
    end

    // Random traffic.
    rnd_env = 1'b1; req_mode = 3; lat_cfg = -1;
    step(3000);
    rnd_env = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
